// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU/multiply-divide encodings and the default datapath width for the execute stage
package ex_pkg;
    localparam int XLEN_DEF = 32;
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;
endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO (start/op/a/b in, flush aborts, busy/hi/lo out, mt_* direct writes)
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    input  logic            mt_hi_we,
    input  logic            mt_lo_we,
    input  logic [XLEN-1:0] mt_data
);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e            state;
    logic [CNT_W-1:0]  cnt;
    md_op_e            op_r;
    logic              sa, sb, sgn_a, sgn_b, is_sgn, is_div;
    logic [XLEN-1:0]   mb, a_raw, mag_a, mag_b, q, r, hi_nxt, lo_nxt;
    logic [XLEN:0]     sum, diff;
    logic [2*XLEN-1:0] acc, nxt, prod;
    assign busy = (state == BUSY);
    // acc holds {partial product | remainder, multiplier | dividend->quotient}
    always_comb begin
        is_sgn = (op == MD_MULT) || (op == MD_DIV);
        sgn_a  = is_sgn & a[XLEN-1];
        sgn_b  = is_sgn & b[XLEN-1];
        mag_a  = sgn_a ? -a : a;
        mag_b  = sgn_b ? -b : b;
        is_div = (op_r == MD_DIV) || (op_r == MD_DIVU);
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb} : '0);
        diff   = acc[2*XLEN-1:XLEN-1] - {1'b0, mb};
        nxt    = is_div ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                      : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                        : {sum, acc[XLEN-1:1]};
        prod   = (sa ^ sb) ? -nxt : nxt;
        q      = (sa ^ sb) ? -nxt[XLEN-1:0] : nxt[XLEN-1:0];
        r      = sa ? -nxt[2*XLEN-1:XLEN] : nxt[2*XLEN-1:XLEN];
        hi_nxt = is_div ? ((mb == '0) ? a_raw : r) : prod[2*XLEN-1:XLEN];
        lo_nxt = is_div ? ((mb == '0) ? '1 : q) : prod[XLEN-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= MD_NONE;
            sa    <= 1'b0;
            sb    <= 1'b0;
            mb    <= '0;
            a_raw <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (busy && flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (busy) begin
                acc <= nxt;
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state <= IDLE;
                    hi    <= hi_nxt;
                    lo    <= lo_nxt;
                end
            end else if (start) begin
                state <= BUSY;
                cnt   <= CNT_W'(XLEN);
                op_r  <= op;
                sa    <= sgn_a;
                sb    <= sgn_b;
                mb    <= mag_b;
                a_raw <= a;
                acc   <= {{XLEN{1'b0}}, mag_a};
            end
            if (mt_hi_we) hi <= mt_data;
            if (mt_lo_we) lo <= mt_data;
        end
    end
endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage, ALU/JAL/LUI/MFHI/MFLO result mux plus iterative mul/div with stall (operands in, alu_out/out_valid/stall/md_busy/a_dbg/b_dbg out)
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic [XLEN-1:0] ext_imm,
    input  logic [15:0]     imm16,
    input  logic            shift,
    input  logic            alu_imm,
    input  logic [2:0]      alu_ctr,
    input  logic            jal,
    input  logic            lui,
    input  logic [XLEN-1:0] pc_p4,
    input  logic [3:0]      md_op,
    output logic [XLEN-1:0] alu_out,
    output logic            out_valid,
    output logic            stall,
    output logic            md_busy,
    output logic [XLEN-1:0] a_dbg,
    output logic [XLEN-1:0] b_dbg
);
    logic [XLEN-1:0] a, b, alu_res, lui_val, hi, lo;
    logic            start, is_md;
    md_op_e          op;
    alu_op_e         ctr;
    always_comb begin
        op      = md_op_e'(md_op);
        ctr     = alu_op_e'(alu_ctr);
        a       = shift ? ext_imm : rs_val;
        b       = alu_imm ? ext_imm : rt_val;
        alu_res = ctr == ALU_AND ? a & b :
                  ctr == ALU_OR  ? a | b :
                  ctr == ALU_ADD ? a + b :
                  ctr == ALU_XOR ? a ^ b :
                  ctr == ALU_NOR ? ~(a | b) :
                  ctr == ALU_SRL ? b >> a[4:0] :
                  ctr == ALU_SUB ? a - b :
                  {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        lui_val = XLEN'({imm16, {XLEN{1'b0}}} >> 16);
        alu_out = jal ? pc_p4 :
                  lui ? lui_val :
                  op == MD_MFHI ? hi :
                  op == MD_MFLO ? lo : alu_res;
        is_md     = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        stall     = in_valid & md_busy & (op != MD_NONE) & ~flush;
        out_valid = in_valid & ~stall & ~flush;
        start     = in_valid & ~md_busy & ~flush & is_md;
        a_dbg     = a;
        b_dbg     = b;
    end
    ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (rs_val),
        .b        (rt_val),
        .flush    (flush),
        .busy     (md_busy),
        .hi       (hi),
        .lo       (lo),
        .mt_hi_we (out_valid & (op == MD_MTHI)),
        .mt_lo_we (out_valid & (op == MD_MTLO)),
        .mt_data  (rs_val)
    );
endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the pipelined MIPS core. It produces the ALU/JAL/LUI result for the EX/MEM register and adds an iterative multiply/divide unit with architectural HI/LO registers. While a multi-cycle operation is in flight, the stage raises a stall so that the hazard unit holds IF/ID/EX. It sits between the ID/EX pipeline register and the EX/MEM pipeline register.

## Interface
Parameters:
- XLEN, 32: datapath width; must be even and at least 8.
- CNT_W, $clog2(XLEN)+1: width of the iteration counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash the instruction currently in EX and abort any multiply/divide in flight.
- in_valid  in  1  ID/EX holds a valid instruction.
- rs_val, rt_val  in  XLEN  forwarded operands.
- ext_imm  in  XLEN  extended immediate.
- imm16  in  16  raw immediate, used by LUI.
- shift, alu_imm  in  1  A-operand select (ext_imm when 1) and B-operand select (ext_imm when 1).
- alu_ctr  in  3  ALU operation, encoded per the package.
- jal, lui  in  1  result overrides.
- pc_p4  in  XLEN  return address.
- md_op  in  4  multiply/divide operation, encoded per the package; MD_NONE for ordinary instructions.
- alu_out  out  XLEN  stage result.
- out_valid  out  1  result is retiring this cycle.
- stall  out  1  hold the upstream stages.
- md_busy  out  1  iteration in progress.
- a_dbg, b_dbg  out  XLEN  selected ALU operands.

## Operation
- A = shift ? ext_imm : rs_val. B = alu_imm ? ext_imm : rt_val.
- ALU encodings: AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101 (shift B right by A[4:0]), SUB 110, SLT 111 (signed). Results wrap modulo 2^XLEN; there is no overflow trap.
- Result priority: jal → pc_p4, then lui → {imm16, XLEN-16 zeros}, then md_op MFHI/MFLO → HI/LO, then the ALU result.
- md_op encodings: MD_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- MTHI/MTLO write rs_val into HI/LO at the clock edge on which the instruction retires.
- Start condition for MULT/MULTU/DIV/DIVU: in_valid, not busy, no flush.
  - At the start edge, latch operand magnitudes, the sign flags and the op; load the counter with XLEN; set busy.
  - The start instruction itself retires with alu_out equal to the ALU result, which is don't-care downstream.
- Multiply: unsigned shift-add, one bit per cycle, on magnitudes. If the operand signs differ and the op is signed, negate the 2·XLEN product on completion.
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(rs) XOR sign(rt).
  - Remainder takes the sign of the dividend.
  - Division by zero: LO = all ones, HI = the original rs_val. No exception.
- Completion: at the edge where the counter reaches 0, write HI/LO and clear busy.
- stall = in_valid & busy & (md_op ≠ MD_NONE) & ~flush.
- out_valid = in_valid & ~stall & ~flush.
- State machine: IDLE → (start) → BUSY → (count = 0) → IDLE. A flush in BUSY returns to IDLE with HI/LO unchanged. Reset forces IDLE.

## Timing
- ALU, JAL, LUI, MFHI and MFLO results are combinational in the cycle the instruction is presented when no stall applies.
- Multiply/divide latency: busy is high for exactly XLEN cycles after the start edge. HI/LO are valid from the first cycle after busy falls.
- A dependent md instruction presented in cycle 1 after the start stalls through cycle XLEN and retires in cycle XLEN+1.
- Simultaneous completion edge and MTHI/MTLO: impossible, because MT* stalls while busy.
- A flush while stall is high: stall drops in the same cycle and nothing retires.
- Reset values: HI = 0, LO = 0, busy = 0, counter = 0, state = IDLE. alu_out follows its inputs; stall and out_valid are 0 once in_valid = 0.
- Reset asserted mid-operation clears state asynchronously. The operation is lost.

## Structure
- Package ex_pkg holds:
  - the alu_op_e encodings;
  - the md_op_e encodings;
  - the ALU_ADD/SUB/… constants;
  - the XLEN default.
- Sub-module ex_muldiv_unit contains the counter, the shift/accumulate datapath, sign fixup and HI/LO. Its ports: start, op, a, b, flush, busy, hi, lo, mt_hi_we, mt_lo_we, mt_data.
- The ALU and the result mux stay in the top level.

## Test plan
- ADD rs=5, rt=7 → alu_out=12 in the same cycle. LUI imm16=0x1234 → 0x12340000. JAL pc_p4=0x00400008 → 0x00400008.
- MULT rs=0xFFFFFFFE, rt=3, then MFLO and MFHI back-to-back:
  - stall is high in cycles 1–32;
  - MFLO → 0xFFFFFFFA in cycle 33;
  - MFHI → 0xFFFFFFFF.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIVU 0x10/0 → LO=0xFFFFFFFF, HI=0x00000010. MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=0x00000001.
- MTHI 0xA5A5A5A5, then DIVU, flush in busy cycle 10:
  - md_busy=0 in the next cycle;
  - a later MFHI → 0xA5A5A5A5.
- rst_n pulsed low mid-MULT → md_busy and stall drop immediately; MFHI/MFLO → 0.
